// File: rtl/muldiv_ctrl.sv
// RV32M multiply/divide sequencer: a registered 33x33 multiply and a 32-step radix-2
// restoring divide, with a valid/ready request side, a result handshake and a kill flush.
module muldiv_ctrl #(
    parameter int unsigned XLEN          = 32,
    parameter bit          DIV_EARLY_OUT = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [2:0]      req_op_i,
    input  logic [XLEN-1:0] req_rs1_i,
    input  logic [XLEN-1:0] req_rs2_i,
    input  logic [4:0]      req_tag_i,
    input  logic            kill_i,
    output logic            res_valid_o,
    input  logic            res_ready_i,
    output logic [XLEN-1:0] res_data_o,
    output logic [4:0]      res_tag_o,
    output logic            busy_o
);

    localparam int unsigned CntW = $clog2(XLEN);

    typedef enum logic [2:0] {
        StIdle,
        StMul,
        StDivIter,
        StDivFix,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [4:0]        tag_q, tag_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   res_q, res_d;
    logic              neg_quo_q, neg_quo_d;
    logic              neg_rem_q, neg_rem_d;
    logic              div_zero_q, div_zero_d;

    // Request-side decode
    logic            accept;
    logic            req_signed;
    logic            req_div_zero;
    logic            req_overflow;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;

    assign req_ready_o  = (state_q == StIdle) && !kill_i;
    assign accept       = req_valid_i && req_ready_o;
    assign req_signed   = !req_op_i[0];
    assign req_div_zero = (req_rs2_i == '0);
    assign req_overflow = req_signed && (req_rs1_i == {1'b1, {(XLEN-1){1'b0}}})
                          && (&req_rs2_i);
    assign abs_a        = (req_signed && req_rs1_i[XLEN-1]) ? -req_rs1_i : req_rs1_i;
    assign abs_b        = (req_signed && req_rs2_i[XLEN-1]) ? -req_rs2_i : req_rs2_i;

    // Multiply: 2*XLEN product of the extended operands equals the 33x33 product mod 2^64
    logic              mul_a_sext;
    logic              mul_b_sext;
    logic [2*XLEN-1:0] mul_a;
    logic [2*XLEN-1:0] mul_b;
    logic [2*XLEN-1:0] product;

    assign mul_a_sext = (op_q != 3'b011);
    assign mul_b_sext = !op_q[1];
    assign mul_a      = {{XLEN{mul_a_sext & a_q[XLEN-1]}}, a_q};
    assign mul_b      = {{XLEN{mul_b_sext & b_q[XLEN-1]}}, b_q};
    assign product    = mul_a * mul_b;

    // Divide step: a_q shifts the dividend out of its top while quotient bits enter at the bottom
    logic [XLEN:0]   rem_shift;
    logic [XLEN-1:0] rem_sub;
    logic            fits;
    logic [XLEN-1:0] quo_fixed;
    logic [XLEN-1:0] rem_fixed;

    assign rem_shift = {rem_q, a_q[XLEN-1]};
    assign fits      = (rem_shift >= {1'b0, b_q});
    assign rem_sub   = rem_shift[XLEN-1:0] - b_q;
    assign quo_fixed = div_zero_q ? '1 : (neg_quo_q ? -a_q : a_q);
    assign rem_fixed = neg_rem_q ? -rem_q : rem_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        tag_d      = tag_q;
        a_d        = a_q;
        b_d        = b_q;
        rem_d      = rem_q;
        res_d      = res_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    op_d  = req_op_i;
                    tag_d = req_tag_i;
                    if (!req_op_i[2]) begin
                        a_d     = req_rs1_i;
                        b_d     = req_rs2_i;
                        state_d = StMul;
                    end else if (DIV_EARLY_OUT && (req_div_zero || req_overflow)) begin
                        // Load final magnitudes directly so DIV_FIX passes them through
                        a_d        = req_div_zero ? '1 : req_rs1_i;
                        b_d        = req_rs2_i;
                        rem_d      = req_div_zero ? req_rs1_i : '0;
                        neg_quo_d  = 1'b0;
                        neg_rem_d  = 1'b0;
                        div_zero_d = req_div_zero;
                        state_d    = StDivFix;
                    end else begin
                        a_d        = abs_a;
                        b_d        = abs_b;
                        rem_d      = '0;
                        neg_quo_d  = req_signed && (req_rs1_i[XLEN-1] ^ req_rs2_i[XLEN-1]);
                        neg_rem_d  = req_signed && req_rs1_i[XLEN-1];
                        div_zero_d = req_div_zero;
                        cnt_d      = CntW'(XLEN - 1);
                        state_d    = StDivIter;
                    end
                end
            end
            StMul: begin
                res_d   = (op_q == 3'b000) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
                state_d = StDone;
            end
            StDivIter: begin
                rem_d = fits ? rem_sub : rem_shift[XLEN-1:0];
                a_d   = {a_q[XLEN-2:0], fits};
                if (cnt_q == '0) begin
                    state_d = StDivFix;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StDivFix: begin
                res_d   = op_q[1] ? rem_fixed : quo_fixed;
                state_d = StDone;
            end
            StDone: begin
                if (res_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (kill_i) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            op_q       <= '0;
            tag_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            rem_q      <= '0;
            res_q      <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            tag_q      <= tag_d;
            a_q        <= a_d;
            b_q        <= b_d;
            rem_q      <= rem_d;
            res_q      <= res_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign res_valid_o = (state_q == StDone) && !kill_i;
    assign res_data_o  = res_q;
    assign res_tag_o   = tag_q;
    assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: two instances (early-out on and off) share the request side and are
// checked against an arithmetic reference model for data, tag, latency and handshake timing.
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic [4:0]  req_tag;
    logic        kill;
    logic        req_ready [2];
    logic        res_valid [2];
    logic        res_ready [2];
    logic [31:0] res_data  [2];
    logic [4:0]  res_tag   [2];
    logic        busy      [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    muldiv_ctrl #(.XLEN(32), .DIV_EARLY_OUT(1'b1)) u_dut_early (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready[0]), .req_op_i(req_op),
        .req_rs1_i(req_rs1), .req_rs2_i(req_rs2), .req_tag_i(req_tag), .kill_i(kill),
        .res_valid_o(res_valid[0]), .res_ready_i(res_ready[0]), .res_data_o(res_data[0]),
        .res_tag_o(res_tag[0]), .busy_o(busy[0])
    );

    muldiv_ctrl #(.XLEN(32), .DIV_EARLY_OUT(1'b0)) u_dut_iter (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready[1]), .req_op_i(req_op),
        .req_rs1_i(req_rs1), .req_rs2_i(req_rs2), .req_tag_i(req_tag), .kill_i(kill),
        .res_valid_o(res_valid[1]), .res_ready_i(res_ready[1]), .res_data_o(res_data[1]),
        .res_tag_o(res_tag[1]), .busy_o(busy[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        logic signed [63:0] sa64;
        logic signed [63:0] sb64;
        logic [63:0]        ua64;
        logic [63:0]        ub64;
        logic [63:0]        p;
        int                 sa;
        int                 sb;
        int                 q;
        sa64 = {{32{a[31]}}, a};
        sb64 = {{32{b[31]}}, b};
        ua64 = {32'b0, a};
        ub64 = {32'b0, b};
        sa   = a;
        sb   = b;
        case (op)
            3'd0: begin p = sa64 * sb64; return p[31:0];  end
            3'd1: begin p = sa64 * sb64; return p[63:32]; end
            3'd2: begin p = sa64 * ub64; return p[63:32]; end
            3'd3: begin p = ua64 * ub64; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                q = sa / sb;
                return q;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                q = sa % sb;
                return q;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input int inst, input logic [2:0] op,
                                       input logic [31:0] a, input logic [31:0] b);
        logic special;
        if (!op[2]) return 2;
        special = (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        return (inst == 0 && special) ? 2 : 34;
    endfunction

    // Entered and left just after a rising edge; hold = extra DONE cycles before res_ready
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag, input int hold);
        logic [31:0] exp_data;
        int          exp_lat [2];
        int          got_lat [2];
        bit          fin     [2];
        exp_data = ref_result(op, a, b);
        for (int i = 0; i < 2; i++) begin
            exp_lat[i] = ref_latency(i, op, a, b);
            got_lat[i] = 0;
            fin[i]     = 1'b0;
        end
        req_valid = 1'b1;
        req_op    = op;
        req_rs1   = a;
        req_rs2   = b;
        req_tag   = tag;
        @(negedge clk);
        check_eq("ready_at_accept0", req_ready[0], 1);
        check_eq("ready_at_accept1", req_ready[1], 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_rs1   = $urandom;
        req_rs2   = $urandom;
        req_tag   = 5'($urandom);
        for (int n = 1; n <= 80 && !(fin[0] && fin[1]); n++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!fin[i]) begin
                    if (got_lat[i] == 0) begin
                        check_eq("busy_in_flight", busy[i], 1);
                        if (res_valid[i]) begin
                            got_lat[i] = n;
                            check_eq("latency", n, exp_lat[i]);
                        end
                    end
                    if (got_lat[i] != 0) begin
                        check_eq("res_valid", res_valid[i], 1);
                        check_eq("res_data", res_data[i], exp_data);
                        check_eq("res_tag", res_tag[i], tag);
                        check_eq("ready_low_in_done", req_ready[i], 0);
                        if (n >= got_lat[i] + hold) begin
                            res_ready[i] = 1'b1;
                            fin[i]       = 1'b1;
                        end
                    end
                end
            end
            @(posedge clk);
            #1;
            res_ready[0] = 1'b0;
            res_ready[1] = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            if (!fin[i]) check_eq("result_timeout", got_lat[i], exp_lat[i]);
        end
        @(negedge clk);
        check_eq("ready_after_handshake0", req_ready[0], 1);
        check_eq("ready_after_handshake1", req_ready[1], 1);
        check_eq("idle_after_handshake", busy[1], 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int i = 0; i < 2; i++) begin
            check_eq({tag, "_res_valid"}, res_valid[i], 0);
            check_eq({tag, "_res_data"}, res_data[i], 0);
            check_eq({tag, "_res_tag"}, res_tag[i], 0);
            check_eq({tag, "_busy"}, busy[i], 0);
            check_eq({tag, "_req_ready"}, req_ready[i], 1);
        end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst          = 1'b0;
        req_valid    = 1'b0;
        req_op       = 3'd0;
        req_rs1      = '0;
        req_rs2      = '0;
        req_tag      = '0;
        kill         = 1'b0;
        res_ready[0] = 1'b0;
        res_ready[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Multiplies
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd7, 0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 0);
        run_op(3'd0, 32'd3, 32'd4, 5'd31, 0);
        run_op(3'd3, 32'hFFFF_FFFF, 32'h0000_0002, 5'd1, 0);
        // Divides, normal and special cases
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd3, 0);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd4, 0);
        run_op(3'd5, 32'd100, 32'd7, 5'd5, 0);
        run_op(3'd7, 32'd100, 32'd7, 5'd6, 0);
        run_op(3'd5, 32'd5, 32'd0, 5'd8, 0);
        run_op(3'd7, 32'd5, 32'd0, 5'd9, 0);
        run_op(3'd4, 32'hFFFF_FFF0, 32'd0, 5'd10, 0);
        run_op(3'd6, 32'hFFFF_FFF0, 32'd0, 5'd11, 0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 0);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 0);
        // Result held in DONE under backpressure
        run_op(3'd5, 32'd100, 32'd7, 5'd21, 5);

        // Kill in cycle 10 of a divide, then a kill that blocks a request in IDLE
        req_valid = 1'b1;
        req_op    = 3'd4;
        req_rs1   = 32'd1000;
        req_rs2   = 32'd3;
        req_tag   = 5'd17;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int n = 1; n <= 13; n++) begin
            if (n == 10) kill = 1'b1;
            if (n == 12) begin
                kill      = 1'b1;
                req_valid = 1'b1;
            end
            @(negedge clk);
            check_eq("kill_no_valid0", res_valid[0], 0);
            check_eq("kill_no_valid1", res_valid[1], 0);
            if (n == 10 || n == 12) check_eq("kill_blocks_ready", req_ready[0], 0);
            if (n == 11 || n == 13) begin
                check_eq("idle_after_kill0", busy[0], 0);
                check_eq("idle_after_kill1", busy[1], 0);
                check_eq("ready_after_kill", req_ready[0], 1);
            end
            @(posedge clk);
            #1;
            kill      = 1'b0;
            req_valid = 1'b0;
        end
        run_op(3'd0, 32'd3, 32'd4, 5'd2, 0);

        // Asynchronous reset in the middle of a divide
        req_valid = 1'b1;
        req_op    = 3'd5;
        req_rs1   = 32'hDEAD_BEEF;
        req_rs2   = 32'd9;
        req_tag   = 5'd25;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        run_op(3'd0, 32'd3, 32'd4, 5'd30, 0);

        // Randomized operations
        for (int k = 0; k < 40; k++) begin
            run_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
                   5'($urandom), $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
Sequencer for the RV32M multiply/divide resource attached to the execute stage.
- Accepts one M-extension operation at a time from execute over a valid/ready handshake.
- Runs a registered multiply or a 32-iteration radix-2 restoring divide.
- Returns the result with its destination-register tag.
- Drives busy_o so execute can stall exactly as it does for LSU backpressure. Trap and jump flushes cancel in-flight work through kill_i.

Parameters:
XLEN, 32, operand/result width; only 32 is supported.
DIV_EARLY_OUT, 1, 1 = divide-by-zero and signed-overflow cases bypass iteration.

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-low reset
req_valid_i  in  1  execute presents an M operation
req_ready_o  out  1  controller can accept
req_op_i  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
req_rs1_i  in  XLEN  operand A (already forwarded)
req_rs2_i  in  XLEN  operand B (already forwarded)
req_tag_i  in  5  rd address
kill_i  in  1  flush; cancels the current op
res_valid_o  out  1  result available
res_ready_i  in  1  consumer takes result
res_data_o  out  XLEN  result
res_tag_o  out  5  rd address of the result
busy_o  out  1  high whenever state != IDLE

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, counter=0, all result/operand registers 0. Outputs: res_valid_o=0, res_data_o=0, res_tag_o=0, busy_o=0, req_ready_o=1.
- Accept rules:
  - req_ready_o = (state==IDLE) && !kill_i.
  - A transfer occurs when req_valid_i && req_ready_o; call this cycle 0.
  - Op, operands and tag are latched at the end of cycle 0.
- States: IDLE, MUL, DIV_ITER, DIV_FIX, DONE.
- IDLE:
  - On accept of op[2]==0 -> MUL.
  - On accept of op[2]==1 -> DIV_ITER, or DIV_FIX when DIV_EARLY_OUT and a special case applies.
- MUL:
  - Forms a 33x33 signed product of operands sign- or zero-extended per op.
  - MULHSU: rs1 is signed, rs2 is unsigned.
  - MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32].
  - Result is registered -> DONE. Result is valid in cycle 2.
- DIV_ITER:
  - At accept, latch |A| and |B|; for signed ops, record quotient sign = sA^sB and remainder sign = sA.
  - Set counter=31.
  - Each cycle: shift the remainder/quotient pair left by 1; subtract the divisor; restore if the result is negative.
  - Exit to DIV_FIX when counter==0; the counter decrements otherwise. This gives exactly 32 iteration cycles (cycles 1..32).
- DIV_FIX:
  - Applies two's-complement sign correction.
  - Selects quotient (DIV/DIVU) or remainder (REM/REMU) and registers it -> DONE.
  - Normal divide result is valid in cycle 34; early-out result is valid in cycle 2.
- Special cases (RISC-V defined, never trap):
  - Divide by zero: quotient = 0xFFFFFFFF (both signed and unsigned); remainder = dividend.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
  - With DIV_EARLY_OUT=0 these cases iterate normally, still produce the same values, and take 34 cycles.
- DONE:
  - res_valid_o = (state==DONE) && !kill_i.
  - res_data_o/res_tag_o are stable while in DONE.
  - Stays in DONE until res_ready_i; on res_ready_i -> IDLE.
  - A new request is not accepted in the same cycle as the result handshake; ready rises the following cycle.
- kill_i:
  - In any non-IDLE state, the next state is IDLE and the result is discarded.
  - res_valid_o is forced low in the kill cycle.
  - A request presented in the same cycle as kill_i is not accepted.
  - kill_i in IDLE has no effect other than deasserting req_ready_o.
- busy_o is registered-state based (state != IDLE), with no combinational path from req_valid_i.
- Reset asserted mid-operation: immediate return to reset values; no partial result is ever presented.
- Operand inputs are don't-care outside the accept cycle.

Test Plan:
- MULH 0x80000000 x 0x80000000: accept in cycle 0 -> res_valid_o in cycle 2, data 0x40000000, tag echoed. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF. MUL 3 x 4 -> 0x0000000C.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD at cycle 34. REM with the same operands -> 0xFFFFFFFF. DIVU 100 / 7 -> 14. REMU 100 / 7 -> 2. busy_o is high in cycles 1..34.
- DIVU 5 / 0 -> 0xFFFFFFFF and REMU 5 / 0 -> 5, both in cycle 2. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0, in cycle 2. Repeat with DIV_EARLY_OUT=0 -> same values in cycle 34.
- Hold res_ready_i low for 5 cycles after DONE -> res_valid_o, data and tag stay stable and req_ready_o stays 0. Release -> req_ready_o returns to 1 one cycle later.
- Pulse kill_i in cycle 10 of a DIV -> res_valid_o never asserts and state is IDLE in cycle 11. Then issue MUL 3 x 4 -> 12 two cycles after accept.
- Drop rst low during DIV_ITER -> all outputs go to reset values immediately (asynchronously). After release, a MUL completes normally.
